// File: rtl/exc_vector_loader_if.sv
// Signal bundle between the exception-entry sequencer and the datapath/memory side.
// The master modport belongs to the sequencer; the slave modport to its environment.
interface exc_vector_loader_if;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data;
  logic [2:0]  mem_addr_sel;
  logic        epc_wr;
  logic [31:0] epc_out;
  logic        pc_wr;
  logic [31:0] pc_out;
  logic [1:0]  cause;
  logic        busy;

  modport master (
    input  exc_opcode, exc_overflow, exc_div0, pc_in, mem_data,
    output mem_addr_sel, epc_wr, epc_out, pc_wr, pc_out, cause, busy
  );

  modport slave (
    output exc_opcode, exc_overflow, exc_div0, pc_in, mem_data,
    input  mem_addr_sel, epc_wr, epc_out, pc_wr, pc_out, cause, busy
  );
endinterface

// File: rtl/exc_vector_loader.sv
// Exception-entry sequencer: saves PC-4 into EPC, selects the vector address,
// waits out the memory latency and loads the zero-extended vector byte into PC.
module exc_vector_loader #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  exc_vector_loader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;

  logic        any_req;
  logic [2:0]  sel_vec;
  logic [2:0]  mem_addr_sel_c;
  logic        epc_wr_c;
  logic        pc_wr_c;
  logic        busy_c;
  logic [31:0] pc_out_c;
  logic        unused_mem_hi;

  assign any_req       = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
  assign unused_mem_hi = ^bus.mem_data[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (bus.exc_opcode)        cause_d = 2'b01;
          else if (bus.exc_overflow) cause_d = 2'b10;
          else                       cause_d = 2'b11;
          epc_d   = bus.pc_in - 32'd4;
          state_d = SAVE;
        end
      end
      SAVE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = LOAD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Cause 00 cannot occur outside IDLE; it maps to 100 so 000 stays an IDLE-only code.
  always_comb begin
    sel_vec = 3'b100;
    case (cause_q)
      2'b10:   sel_vec = 3'b101;
      2'b11:   sel_vec = 3'b110;
      default: sel_vec = 3'b100;
    endcase
  end

  always_comb begin
    mem_addr_sel_c = 3'b000;
    epc_wr_c       = 1'b0;
    pc_wr_c        = 1'b0;
    busy_c         = 1'b0;
    pc_out_c       = '0;
    case (state_q)
      SAVE: begin
        mem_addr_sel_c = sel_vec;
        epc_wr_c       = 1'b1;
        busy_c         = 1'b1;
      end
      WAIT: begin
        mem_addr_sel_c = sel_vec;
        busy_c         = 1'b1;
      end
      LOAD: begin
        mem_addr_sel_c = sel_vec;
        pc_wr_c        = 1'b1;
        busy_c         = 1'b1;
        pc_out_c       = {24'b0, bus.mem_data[7:0]};
      end
      default: begin
        mem_addr_sel_c = 3'b000;
      end
    endcase
  end

  assign bus.mem_addr_sel = mem_addr_sel_c;
  assign bus.epc_wr       = epc_wr_c;
  assign bus.pc_wr        = pc_wr_c;
  assign bus.busy         = busy_c;
  assign bus.pc_out       = pc_out_c;
  assign bus.epc_out      = epc_q;
  assign bus.cause        = cause_q;

endmodule

// File: tb/tb_exc_vector_loader.sv
// Scoreboard bench: stimulus pushes expected EPC/PC writes, negedge monitors pop and compare.
// Two instances: latency 2 for the directed sequences, latency 1 for back-to-back wrap.
module tb_exc_vector_loader;

  typedef struct {
    logic        is_pc;
    logic [31:0] data;
    logic [2:0]  sel;
    logic [1:0]  cause;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   b_epc_count = 0;
  time  b_last_epc = 0;

  exp_t qa[$];
  exp_t qb[$];

  exc_vector_loader_if bus_a();
  exc_vector_loader_if bus_b();

  exc_vector_loader #(.MEM_LATENCY(2)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  exc_vector_loader #(.MEM_LATENCY(1)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] vec_word(input logic [2:0] sel);
    case (sel)
      3'b100:  return 32'h1234_5610;
      3'b101:  return 32'hAABB_CC7C;
      3'b110:  return 32'hFFFF_FF99;
      default: return 32'hDEAD_BE00;
    endcase
  endfunction

  // Memory models: data valid only once the select has been stable for the latency.
  logic [2:0] a_last = 3'b000, b_last = 3'b000;
  int         a_age = 0, b_age = 0;
  always @(posedge clk) begin
    if (bus_a.mem_addr_sel == 3'b000)        a_age <= 0;
    else if (bus_a.mem_addr_sel != a_last)   a_age <= 1;
    else                                     a_age <= a_age + 1;
    a_last <= bus_a.mem_addr_sel;
    if (bus_b.mem_addr_sel == 3'b000)        b_age <= 0;
    else if (bus_b.mem_addr_sel != b_last)   b_age <= 1;
    else                                     b_age <= b_age + 1;
    b_last <= bus_b.mem_addr_sel;
  end
  assign bus_a.mem_data = (bus_a.mem_addr_sel != 3'b000 && bus_a.mem_addr_sel == a_last && a_age >= 2)
                          ? vec_word(bus_a.mem_addr_sel) : 32'hDEAD_BE00;
  assign bus_b.mem_data = (bus_b.mem_addr_sel != 3'b000 && bus_b.mem_addr_sel == b_last && b_age >= 1)
                          ? vec_word(bus_b.mem_addr_sel) : 32'hDEAD_BE00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=pulse required=none", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [31:0] epc, input logic [31:0] pc, input logic [2:0] sel,
                        input logic [1:0] cause, input bit with_pc);
    qa.push_back('{is_pc: 1'b0, data: epc, sel: sel, cause: cause});
    if (with_pc) qa.push_back('{is_pc: 1'b1, data: pc, sel: sel, cause: cause});
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.epc_wr) begin
      if (qa.size() == 0) unexpected("a_epc_wr");
      else begin
        e = qa.pop_front();
        $display("txn A epc_wr epc=%h sel=%b cause=%b", bus_a.epc_out, bus_a.mem_addr_sel, bus_a.cause);
        chk("a_kind_epc", {31'b0, e.is_pc}, 32'd0);
        chk("a_epc_out", bus_a.epc_out, e.data);
        chk("a_epc_sel", {29'b0, bus_a.mem_addr_sel}, {29'b0, e.sel});
      end
    end
    if (bus_a.pc_wr) begin
      if (qa.size() == 0) unexpected("a_pc_wr");
      else begin
        e = qa.pop_front();
        $display("txn A pc_wr pc=%h sel=%b cause=%b", bus_a.pc_out, bus_a.mem_addr_sel, bus_a.cause);
        chk("a_kind_pc", {31'b0, e.is_pc}, 32'd1);
        chk("a_pc_out", bus_a.pc_out, e.data);
        chk("a_pc_sel", {29'b0, bus_a.mem_addr_sel}, {29'b0, e.sel});
        chk("a_pc_cause", {30'b0, bus_a.cause}, {30'b0, e.cause});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.epc_wr) begin
      b_epc_count++;
      if (b_last_epc != 0) chk("b_period", 32'($time - b_last_epc), 32'd40);
      b_last_epc = $time;
      if (qb.size() == 0) unexpected("b_epc_wr");
      else begin
        e = qb.pop_front();
        $display("txn B epc_wr epc=%h sel=%b", bus_b.epc_out, bus_b.mem_addr_sel);
        chk("b_kind_epc", {31'b0, e.is_pc}, 32'd0);
        chk("b_epc_out", bus_b.epc_out, e.data);
        chk("b_epc_sel", {29'b0, bus_b.mem_addr_sel}, {29'b0, e.sel});
      end
    end
    if (bus_b.pc_wr) begin
      if (qb.size() == 0) unexpected("b_pc_wr");
      else begin
        e = qb.pop_front();
        $display("txn B pc_wr pc=%h sel=%b", bus_b.pc_out, bus_b.mem_addr_sel);
        chk("b_kind_pc", {31'b0, e.is_pc}, 32'd1);
        chk("b_pc_out", bus_b.pc_out, e.data);
      end
    end
  end

  initial begin
    bus_a.exc_opcode = 1'b0; bus_a.exc_overflow = 1'b0; bus_a.exc_div0 = 1'b0; bus_a.pc_in = '0;
    bus_b.exc_opcode = 1'b0; bus_b.exc_overflow = 1'b0; bus_b.exc_div0 = 1'b0; bus_b.pc_in = '0;

    // Reset values
    cyc(3);
    chk("rst_sel", {29'b0, bus_a.mem_addr_sel}, 32'd0);
    chk("rst_epc_wr", {31'b0, bus_a.epc_wr}, 32'd0);
    chk("rst_pc_wr", {31'b0, bus_a.pc_wr}, 32'd0);
    chk("rst_pc_out", bus_a.pc_out, 32'd0);
    chk("rst_epc_out", bus_a.epc_out, 32'd0);
    chk("rst_cause", {30'b0, bus_a.cause}, 32'd0);
    chk("rst_busy", {31'b0, bus_a.busy}, 32'd0);
    reset_a = 1'b0;
    cyc(2);
    chk("idle_sel", {29'b0, bus_a.mem_addr_sel}, 32'd0);
    chk("idle_busy", {31'b0, bus_a.busy}, 32'd0);

    // Overflow sequence
    bus_a.pc_in = 32'h0000_0040; bus_a.exc_overflow = 1'b1;
    push_a(32'h0000_003C, 32'h0000_007C, 3'b101, 2'b10, 1'b1);
    cyc(1);
    bus_a.exc_overflow = 1'b0;
    chk("ovf_epc_wr", {31'b0, bus_a.epc_wr}, 32'd1);
    chk("ovf_epc_out", bus_a.epc_out, 32'h0000_003C);
    chk("ovf_sel", {29'b0, bus_a.mem_addr_sel}, 32'd5);
    chk("ovf_busy", {31'b0, bus_a.busy}, 32'd1);
    cyc(3);
    chk("ovf_pc_wr", {31'b0, bus_a.pc_wr}, 32'd1);
    chk("ovf_pc_out", bus_a.pc_out, 32'h0000_007C);
    chk("ovf_cause", {30'b0, bus_a.cause}, 32'd2);
    cyc(1);
    chk("ovf_done_busy", {31'b0, bus_a.busy}, 32'd0);
    chk("ovf_done_sel", {29'b0, bus_a.mem_addr_sel}, 32'd0);
    chk("ovf_cause_kept", {30'b0, bus_a.cause}, 32'd2);

    // Priority
    bus_a.pc_in = 32'h0000_1000;
    bus_a.exc_opcode = 1'b1; bus_a.exc_overflow = 1'b1; bus_a.exc_div0 = 1'b1;
    push_a(32'h0000_0FFC, 32'h0000_0010, 3'b100, 2'b01, 1'b1);
    cyc(1);
    bus_a.exc_opcode = 1'b0; bus_a.exc_overflow = 1'b0; bus_a.exc_div0 = 1'b0;
    chk("pri_sel", {29'b0, bus_a.mem_addr_sel}, 32'd4);
    chk("pri_cause", {30'b0, bus_a.cause}, 32'd1);
    cyc(5);
    chk("pri_done_busy", {31'b0, bus_a.busy}, 32'd0);

    // Ignore while busy
    bus_a.pc_in = 32'h0000_2000; bus_a.exc_div0 = 1'b1;
    push_a(32'h0000_1FFC, 32'h0000_0099, 3'b110, 2'b11, 1'b1);
    cyc(1);
    bus_a.exc_div0 = 1'b0; bus_a.exc_opcode = 1'b1;
    cyc(1);
    bus_a.exc_opcode = 1'b0;
    chk("ign_sel", {29'b0, bus_a.mem_addr_sel}, 32'd6);
    chk("ign_cause", {30'b0, bus_a.cause}, 32'd3);
    cyc(4);
    chk("ign_done_busy", {31'b0, bus_a.busy}, 32'd0);
    cyc(3);
    chk("ign_no_resave", {31'b0, bus_a.busy}, 32'd0);

    // Reset mid-WAIT
    bus_a.pc_in = 32'h0000_3000; bus_a.exc_div0 = 1'b1;
    push_a(32'h0000_2FFC, 32'h0, 3'b110, 2'b11, 1'b0);
    cyc(1);
    bus_a.exc_div0 = 1'b0;
    cyc(1);
    chk("rw_wait_busy", {31'b0, bus_a.busy}, 32'd1);
    chk("rw_wait_sel", {29'b0, bus_a.mem_addr_sel}, 32'd6);
    reset_a = 1'b1;
    cyc(1);
    chk("rw_sel", {29'b0, bus_a.mem_addr_sel}, 32'd0);
    chk("rw_busy", {31'b0, bus_a.busy}, 32'd0);
    chk("rw_cause", {30'b0, bus_a.cause}, 32'd0);
    chk("rw_epc_out", bus_a.epc_out, 32'd0);
    reset_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("rw_no_pc_wr", {31'b0, bus_a.pc_wr}, 32'd0);
    end

    // Back-to-back with PC wrap, latency 1
    reset_b = 1'b0;
    cyc(1);
    bus_b.pc_in = 32'h0; bus_b.exc_div0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      qb.push_back('{is_pc: 1'b0, data: 32'hFFFF_FFFC, sel: 3'b110, cause: 2'b11});
      qb.push_back('{is_pc: 1'b1, data: 32'h0000_0099, sel: 3'b110, cause: 2'b11});
    end
    cyc(14);
    bus_b.exc_div0 = 1'b0;
    cyc(6);
    chk("b_seq_count", 32'(b_epc_count), 32'd4);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_vector_loader.md
# exc_vector_loader

Exception-entry sequencer for the multicycle MIPS datapath. On an exception request it saves the faulting PC into EPC and drives the memory-address mux select to the matching vector address (253, 254 or 255). It then waits out the memory read latency, zero-extends the returned vector byte and writes it into PC. It is the consumer side of the memory-address selector: it issues codes `3'b100`, `3'b101` and `3'b110` and reads back what memory returns for them.

## Interface
Parameters:
- MEM_LATENCY, 2, cycles from address-select valid to `mem_data` valid; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- exc_opcode  in  1  nonexistent-opcode exception request
- exc_overflow  in  1  arithmetic overflow exception request
- exc_div0  in  1  divide-by-zero exception request
- pc_in  in  32  current PC value, already incremented by 4
- mem_data  in  32  memory read data; the vector byte is `mem_data[7:0]`
- mem_addr_sel  out  3  memory-address mux select
- epc_wr  out  1  EPC write enable, one-cycle pulse
- epc_out  out  32  EPC write data
- pc_wr  out  1  PC write enable, one-cycle pulse
- pc_out  out  32  PC write data
- cause  out  2  latched cause: 01 opcode, 10 overflow, 11 div0, 00 none
- busy  out  1  high while a sequence is in progress

## Operation
- States: IDLE, SAVE, WAIT, LOAD.
- **IDLE**
  - Requests are sampled on each rising edge.
  - If any request is high, latch the cause with priority opcode > overflow > div0.
  - At the same edge, latch `epc_reg = pc_in - 32'd4` (modulo 2^32) and go to SAVE.
- **SAVE** (1 cycle)
  - `epc_wr=1`.
  - `mem_addr_sel` set by cause: 01→100, 10→101, 11→110.
  - Load the wait counter with MEM_LATENCY-1 and go to WAIT.
- **WAIT** (MEM_LATENCY cycles)
  - `mem_addr_sel` is held.
  - The counter decrements each cycle; when it is 0, go to LOAD.
- **LOAD** (1 cycle)
  - `pc_wr=1` and `pc_out = {24'b0, mem_data[7:0]}`, taken combinationally from `mem_data` this cycle.
  - `mem_addr_sel` is still held.
  - Go to IDLE.
- Request inputs are ignored outside IDLE; requests raised during a sequence are lost, not queued.
- In IDLE:
  - `mem_addr_sel=000`, `busy=0`, `epc_wr=0`, `pc_wr=0`.
  - `cause` keeps its last value until the next accepted request.
- `epc_out = epc_reg` at all times.
- `busy=1` in SAVE, WAIT and LOAD.
- All outputs except `pc_out` are decoded from registered state only.
- The block never drives code 000 except in IDLE, and never drives codes 001, 010, 011 or 111.

## Timing
- Reset:
  - state=IDLE, counter=0, `epc_reg=0`, `cause=00`.
  - `mem_addr_sel=000`, `epc_wr=0`, `pc_wr=0`, `pc_out=0` (LOAD inactive), `busy=0`.
- Reset asserted mid-sequence: the next edge returns to IDLE with reset values. No `pc_wr` pulse is emitted afterward, and a partially completed EPC write is not repeated.
- Request seen at edge k:
  - SAVE during cycle k+1.
  - WAIT during cycles k+2 .. k+1+MEM_LATENCY.
  - LOAD during cycle k+2+MEM_LATENCY.
  - IDLE again at edge k+3+MEM_LATENCY; a request held at that edge is accepted.
- Busy duration: MEM_LATENCY+2 cycles.
- Simultaneous requests: the highest-priority request wins and the others are dropped.
- `pc_in=0` gives `epc_out=32'hFFFF_FFFC`.

## Test plan
- **Reset values:** hold reset for 3 cycles → all outputs 0 and `busy=0`; release reset with no requests → `mem_addr_sel` stays 000.
- **Overflow sequence (MEM_LATENCY=2):**
  - Stimulus: `exc_overflow` pulsed at edge k, `pc_in=32'h0000_0040`, memory returns `32'hAABB_CC7C`.
  - Cycle k+1: `epc_wr=1`, `epc_out=32'h3C`, `mem_addr_sel=101`.
  - Cycle k+4: `pc_wr=1`, `pc_out=32'h7C`, `cause=10`.
  - Edge k+5: `busy=0`.
- **Priority:** `exc_opcode`, `exc_overflow` and `exc_div0` all high together → `cause=01`, `mem_addr_sel=100`, exactly one `pc_wr` pulse.
- **Ignore while busy:** `exc_div0` at edge k, `exc_opcode` pulsed at k+2 → single sequence with `mem_addr_sel=110`; no second SAVE after returning to IDLE.
- **Reset mid-WAIT:** reset during cycle k+2 → at edge k+3 state is IDLE, `mem_addr_sel=000`; `pc_wr` never asserts.
- **Back-to-back and wrap:**
  - Stimulus: `exc_div0` held high continuously, `pc_in=0`, MEM_LATENCY=1.
  - Response: a new SAVE every 4 cycles, `epc_out=32'hFFFF_FFFC` each time.
